// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types and constants for the ALU operation sequencer.
//   op_e      - request opcodes understood by the sequencer (ADD..MUL)
//   SEL_*     - {s4,s3,s2,s1} ALU select codes for each opcode
//   state_e   - sequencer FSM states
//   MUL_STEPS - shift-and-add iterations for the 4x4 multiply
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_INC = 4'd2,
    OP_DEC = 4'd3,
    OP_XOR = 4'd4,
    OP_OR  = 4'd5,
    OP_AND = 4'd6,
    OP_ASR = 4'd7,
    OP_MUL = 4'd8
  } op_e;

  localparam logic [3:0] SEL_ADD  = 4'b0000;
  localparam logic [3:0] SEL_SUB  = 4'b0001;
  localparam logic [3:0] SEL_INC  = 4'b0010;
  localparam logic [3:0] SEL_DEC  = 4'b0011;
  localparam logic [3:0] SEL_XOR  = 4'b0100;
  localparam logic [3:0] SEL_OR   = 4'b0110;
  localparam logic [3:0] SEL_AND  = 4'b0111;
  localparam logic [3:0] SEL_ASR  = 4'b1000;
  localparam logic [3:0] SEL_NONE = 4'b0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  localparam int MUL_STEPS = 4;

endpackage

// File: rtl/alu_seq_decode.sv
// alu_seq_decode: combinational opcode decoder.
//   op      in  4  request opcode
//   alu_sel out 4  {s4,s3,s2,s1} select for the ALU (0 for illegal opcodes)
//   is_mul  out 1  opcode is the shift-and-add multiply
//   illegal out 1  opcode is outside the supported set
module alu_seq_decode
  import alu_seq_pkg::*;
(
  input  logic [3:0] op,
  output logic [3:0] alu_sel,
  output logic       is_mul,
  output logic       illegal
);

  // Opcode to ALU select / class lookup.
  always_comb begin
    alu_sel = SEL_NONE;
    is_mul  = 1'b0;
    illegal = 1'b0;
    case (op)
      OP_ADD:  alu_sel = SEL_ADD;
      OP_SUB:  alu_sel = SEL_SUB;
      OP_INC:  alu_sel = SEL_INC;
      OP_DEC:  alu_sel = SEL_DEC;
      OP_XOR:  alu_sel = SEL_XOR;
      OP_OR:   alu_sel = SEL_OR;
      OP_AND:  alu_sel = SEL_AND;
      OP_ASR:  alu_sel = SEL_ASR;
      OP_MUL: begin
        // The multiply reuses the ADD path for every partial-product step.
        alu_sel = SEL_ADD;
        is_mul  = 1'b1;
      end
      default: begin
        alu_sel = SEL_NONE;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issues operations to an external 4-bit combinational ALU.
//   clk, rst_n              clock, async active-low reset
//   req_valid/ready         request handshake (ready only in IDLE)
//   req_op, req_a, req_b    opcode and 4-bit operands
//   resp_valid/ready        response handshake
//   resp_data, resp_err     8-bit result, illegal-opcode flag
//   alu_a, alu_b, alu_sel   registered drive to the ALU (0 outside EXEC/MUL)
//   alu_o                   5-bit ALU result, sampled only in EXEC/MUL
//   busy                    sequencer not in IDLE
// All outputs come straight from flops, so the ALU sees a full cycle.
module alu_op_sequencer #(
  parameter int MUL_STEPS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_op,
  input  logic [3:0] req_a,
  input  logic [3:0] req_b,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic [7:0] resp_data,
  output logic       resp_err,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [3:0] alu_sel,
  input  logic [4:0] alu_o,
  output logic       busy
);

  import alu_seq_pkg::*;

  localparam logic [1:0] LAST_STEP = 2'(MUL_STEPS - 1);

  state_e     state_q, state_d;
  logic [3:0] a_q, a_d;
  logic       illegal_q, illegal_d;
  logic [3:0] p_hi_q, p_hi_d;
  logic [3:0] p_lo_q, p_lo_d;
  logic [1:0] step_q, step_d;
  logic [7:0] resp_data_q, resp_data_d;
  logic       resp_err_q, resp_err_d;
  logic       resp_valid_q, resp_valid_d;
  logic       req_ready_q, req_ready_d;
  logic       busy_q, busy_d;
  logic [3:0] alu_a_q, alu_a_d;
  logic [3:0] alu_b_q, alu_b_d;
  logic [3:0] alu_sel_q, alu_sel_d;

  logic [3:0] dec_sel_s;
  logic       dec_is_mul_s;
  logic       dec_illegal_s;
  logic       mul_c_s;
  logic [3:0] mul_hi_s;

  alu_seq_decode u_decode (
    .op      (req_op),
    .alu_sel (dec_sel_s),
    .is_mul  (dec_is_mul_s),
    .illegal (dec_illegal_s)
  );

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    illegal_d   = illegal_q;
    p_hi_d      = p_hi_q;
    p_lo_d      = p_lo_q;
    step_d      = step_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
    mul_c_s     = 1'b0;
    mul_hi_s    = p_hi_q;
    alu_a_d     = 4'd0;
    alu_b_d     = 4'd0;
    alu_sel_d   = SEL_NONE;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          a_d       = req_a;
          illegal_d = dec_illegal_s;
          if (dec_is_mul_s) begin
            state_d = ST_MUL;
            step_d  = 2'd0;
            p_hi_d  = 4'd0;
            p_lo_d  = req_b;
          end else begin
            state_d = ST_EXEC;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (illegal_q) begin
          resp_data_d = 8'h00;
          resp_err_d  = 1'b1;
        end else begin
          resp_data_d = {3'b000, alu_o};
          resp_err_d  = 1'b0;
        end
        state_d = ST_RESP;
      end
      ST_MUL: begin
        // Add the multiplicand only when the current multiplier bit is set;
        // the carry becomes the new MSB of the shifted product.
        if (p_lo_q[0]) begin
          {mul_c_s, mul_hi_s} = alu_o;
        end else begin
          mul_c_s  = 1'b0;
          mul_hi_s = p_hi_q;
        end
        p_hi_d = {mul_c_s, mul_hi_s[3:1]};
        p_lo_d = {mul_hi_s[0], p_lo_q[3:1]};
        if (step_q == LAST_STEP) begin
          step_d      = 2'd0;
          resp_data_d = {p_hi_d, p_lo_d};
          resp_err_d  = 1'b0;
          state_d     = ST_RESP;
        end else begin
          step_d = step_q + 2'd1;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // ALU drive is precomputed for the state being entered so it is stable
    // from the start of EXEC/MUL; illegal ops leave the ALU undriven.
    if ((state_d == ST_EXEC) && !illegal_d) begin
      alu_a_d   = a_d;
      alu_b_d   = req_b;
      alu_sel_d = dec_sel_s;
    end else if (state_d == ST_MUL) begin
      alu_a_d   = p_hi_d;
      alu_b_d   = a_d;
      alu_sel_d = SEL_ADD;
    end else begin
      alu_a_d   = 4'd0;
      alu_b_d   = 4'd0;
      alu_sel_d = SEL_NONE;
    end

    req_ready_d  = (state_d == ST_IDLE);
    resp_valid_d = (state_d == ST_RESP);
    busy_d       = (state_d != ST_IDLE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      a_q          <= 4'd0;
      illegal_q    <= 1'b0;
      p_hi_q       <= 4'd0;
      p_lo_q       <= 4'd0;
      step_q       <= 2'd0;
      resp_data_q  <= 8'h00;
      resp_err_q   <= 1'b0;
      resp_valid_q <= 1'b0;
      req_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      alu_a_q      <= 4'd0;
      alu_b_q      <= 4'd0;
      alu_sel_q    <= SEL_NONE;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      illegal_q    <= illegal_d;
      p_hi_q       <= p_hi_d;
      p_lo_q       <= p_lo_d;
      step_q       <= step_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
      resp_valid_q <= resp_valid_d;
      req_ready_q  <= req_ready_d;
      busy_q       <= busy_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_sel_q    <= alu_sel_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;
  assign busy       = busy_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_sel    = alu_sel_q;

endmodule
